// File: rtl/opendap_swd_host_pkg.sv
// -----------------------------------------------------------------------------
// opendap_swd_host_pkg
// Shared definitions for the SWD host: FSM state encoding, ACK codes,
// request-packet bit positions and parity helpers.
// -----------------------------------------------------------------------------
package opendap_swd_host_pkg;

  // Protocol phases of one command; every state except IDLE and DONE
  // consumes whole SWCLK bit periods.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RAW   = 4'd1,
    ST_REQ   = 4'd2,
    ST_TRN1  = 4'd3,
    ST_ACK   = 4'd4,
    ST_RDATA = 4'd5,
    ST_TRN2  = 4'd6,
    ST_WDATA = 4'd7,
    ST_TAIL  = 4'd8,
    ST_DONE  = 4'd9
  } swd_state_e;

  // ACK codes as assembled LSB-first from the wire.
  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  // Bit positions inside the 8-bit request, bit 0 goes out first.
  localparam int REQ_START  = 0;
  localparam int REQ_APNDP  = 1;
  localparam int REQ_RNW    = 2;
  localparam int REQ_A2     = 3;
  localparam int REQ_A3     = 4;
  localparam int REQ_PARITY = 5;
  localparam int REQ_STOP   = 6;
  localparam int REQ_PARK   = 7;

  // Even parity over a 32-bit data word.
  function automatic logic parity32(input logic [31:0] data);
    return ^data;
  endfunction

  // Assemble the request byte in wire order.
  function automatic logic [7:0] swd_request(input logic       apndp,
                                             input logic       rnw,
                                             input logic [1:0] addr);
    logic [7:0] req;
    req             = 8'h00;
    req[REQ_START]  = 1'b1;
    req[REQ_APNDP]  = apndp;
    req[REQ_RNW]    = rnw;
    req[REQ_A2]     = addr[0];
    req[REQ_A3]     = addr[1];
    req[REQ_PARITY] = apndp ^ rnw ^ addr[0] ^ addr[1];
    req[REQ_STOP]   = 1'b0;
    req[REQ_PARK]   = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/opendap_swd_host_clkgen.sv
// -----------------------------------------------------------------------------
// opendap_swd_host_clkgen
// SWCLK divider. Each bit is a low phase followed by a high phase, each
// clkdiv+1 clk cycles long. The divisor is latched on start.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   start           command accepted: latch clkdiv, begin a low phase
//   en              bit phases running (outside IDLE/DONE)
//   clkdiv          half-bit period minus one
//   fall_stb        last cycle of a high phase (next bit is driven after it)
//   sample_stb      last cycle of a low phase (swdio_i sampled here)
//   rise_stb        cycle after which swclk_o rises (same cycle as sample)
//   swclk_o         registered SWCLK
// -----------------------------------------------------------------------------
module opendap_swd_host_clkgen #(
  parameter int W_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [W_DIV-1:0] clkdiv,
  output logic             fall_stb,
  output logic             sample_stb,
  output logic             rise_stb,
  output logic             swclk_o
);

  logic [W_DIV-1:0] div_r;
  logic [W_DIV-1:0] cnt_r;
  logic             phase_r;   // 0 = low phase, 1 = high phase
  logic             last_s;

  // The counter stops at div_r and restarts, so an all-ones divisor never wraps.
  assign last_s     = (cnt_r == div_r);
  assign sample_stb = en && !phase_r && last_s;
  assign rise_stb   = en && !phase_r && last_s;
  assign fall_stb   = en &&  phase_r && last_s;

  // Half-period counter and SWCLK phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r   <= '0;
      cnt_r   <= '0;
      phase_r <= 1'b0;
      swclk_o <= 1'b0;
    end else if (start) begin
      div_r   <= clkdiv;
      cnt_r   <= '0;
      phase_r <= 1'b0;
      swclk_o <= 1'b0;
    end else if (en) begin
      if (last_s) begin
        cnt_r   <= '0;
        phase_r <= ~phase_r;
        swclk_o <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + W_DIV'(1);
      end
    end else begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
      swclk_o <= 1'b0;
    end
  end

endmodule

// File: rtl/opendap_swd_host.sv
// -----------------------------------------------------------------------------
// opendap_swd_host
// SWD initiator: runs one command at a time, either a raw line sequence
// (up to 32 bits, LSB first) or a full SWD transfer (request, turnaround,
// ACK, optional data+parity, turnaround, idle tail), and reports ACK,
// read data and a read-parity error flag.
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   clkdiv                     half-bit period minus one, latched on accept
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_raw, cmd_raw_len       raw sequence select and length-1
//   cmd_apndp, cmd_rnw, cmd_addr   request fields
//   cmd_wdata                  write data or raw bit pattern
//   rsp_valid                  one-cycle completion pulse
//   rsp_ack, rsp_rdata, rsp_parity_err   response, held until next completion
//   swclk_o, swdio_o, swdio_oe, swdio_i  pad-side SWD signals
// -----------------------------------------------------------------------------
module opendap_swd_host
  import opendap_swd_host_pkg::*;
#(
  parameter int W_DIV       = 8,
  parameter int IDLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_DIV-1:0] clkdiv,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_raw,
  input  logic [4:0]       cmd_raw_len,
  input  logic             cmd_apndp,
  input  logic             cmd_rnw,
  input  logic [1:0]       cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic [2:0]       rsp_ack,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_parity_err,
  output logic             swclk_o,
  output logic             swdio_o,
  output logic             swdio_oe,
  input  logic             swdio_i
);

  localparam logic [5:0] TAIL_LAST = (IDLE_CYCLES > 0) ? 6'(IDLE_CYCLES - 1) : 6'd0;
  localparam swd_state_e AFTER_DATA = (IDLE_CYCLES > 0) ? ST_TAIL : ST_DONE;

  swd_state_e  state_r;
  logic [5:0]  bit_cnt_r;
  logic        raw_r;
  logic [4:0]  raw_len_r;
  logic        rnw_r;
  logic [7:0]  req_r;
  logic [31:0] wdata_r;
  logic [2:0]  ack_r;
  logic [31:0] rdata_sh_r;
  logic        rx_par_r;
  logic        cmd_ready_r;
  logic        rsp_valid_r;
  logic        swdio_o_r;
  logic        swdio_oe_r;

  logic        accept_s;
  logic        bits_en_s;
  logic        fall_s;
  logic        sample_s;
  logic        rise_s;
  logic        ack_ok_s;
  logic [5:0]  last_idx_s;
  swd_state_e  after_s;
  swd_state_e  nxt_state_s;
  logic [5:0]  nxt_idx_s;
  logic        drv_o_s;
  logic        drv_oe_s;

  assign accept_s  = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
  assign bits_en_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign ack_ok_s  = (ack_r == ACK_OK);

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign swdio_o   = swdio_o_r;
  assign swdio_oe  = swdio_oe_r;

  opendap_swd_host_clkgen #(
    .W_DIV (W_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept_s),
    .en         (bits_en_s),
    .clkdiv     (clkdiv),
    .fall_stb   (fall_s),
    .sample_stb (sample_s),
    .rise_stb   (rise_s),
    .swclk_o    (swclk_o)
  );

  // Length of the current phase and the phase that follows it.
  always_comb begin
    last_idx_s = 6'd0;
    after_s    = ST_IDLE;
    case (state_r)
      ST_RAW:   begin last_idx_s = {1'b0, raw_len_r}; after_s = ST_DONE; end
      ST_REQ:   begin last_idx_s = 6'd7;  after_s = ST_TRN1; end
      ST_TRN1:  begin last_idx_s = 6'd0;  after_s = ST_ACK; end
      // ack_r is complete here: the last ACK bit was sampled before this bit's fall.
      ST_ACK:   begin last_idx_s = 6'd2;  after_s = (ack_ok_s && rnw_r) ? ST_RDATA : ST_TRN2; end
      ST_RDATA: begin last_idx_s = 6'd32; after_s = ST_TRN2; end
      ST_TRN2:  begin last_idx_s = 6'd0;  after_s = (ack_ok_s && !rnw_r) ? ST_WDATA : AFTER_DATA; end
      ST_WDATA: begin last_idx_s = 6'd32; after_s = AFTER_DATA; end
      ST_TAIL:  begin last_idx_s = TAIL_LAST; after_s = ST_DONE; end
      default:  begin last_idx_s = 6'd0;  after_s = ST_IDLE; end
    endcase
  end

  // Position of the next bit and the pad values it needs.
  always_comb begin
    if (bit_cnt_r == last_idx_s) begin
      nxt_state_s = after_s;
      nxt_idx_s   = 6'd0;
    end else begin
      nxt_state_s = state_r;
      nxt_idx_s   = bit_cnt_r + 6'd1;
    end
    drv_o_s  = swdio_o_r;
    drv_oe_s = 1'b0;
    case (nxt_state_s)
      ST_RAW:   begin drv_oe_s = 1'b1; drv_o_s = wdata_r[nxt_idx_s[4:0]]; end
      ST_REQ:   begin drv_oe_s = 1'b1; drv_o_s = req_r[nxt_idx_s[2:0]]; end
      ST_WDATA: begin
        drv_oe_s = 1'b1;
        if (nxt_idx_s == 6'd32) begin
          drv_o_s = parity32(wdata_r);
        end else begin
          drv_o_s = wdata_r[nxt_idx_s[4:0]];
        end
      end
      ST_TAIL:  begin drv_oe_s = 1'b1; drv_o_s = 1'b0; end
      // A finished transfer leaves the host driving; a raw sequence keeps its last state.
      ST_DONE:  begin drv_oe_s = raw_r ? swdio_oe_r : 1'b1; drv_o_s = swdio_o_r; end
      default:  begin drv_oe_s = 1'b0; drv_o_s = swdio_o_r; end
    endcase
  end

  // Command FSM: accept, per-bit sequencing, sampling and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      bit_cnt_r      <= 6'd0;
      raw_r          <= 1'b0;
      raw_len_r      <= 5'd0;
      rnw_r          <= 1'b0;
      req_r          <= 8'h00;
      wdata_r        <= 32'h0000_0000;
      ack_r          <= 3'b000;
      rdata_sh_r     <= 32'h0000_0000;
      rx_par_r       <= 1'b0;
      cmd_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_ack        <= 3'b000;
      rsp_rdata      <= 32'h0000_0000;
      rsp_parity_err <= 1'b0;
      swdio_o_r      <= 1'b1;
      swdio_oe_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            raw_r       <= cmd_raw;
            raw_len_r   <= cmd_raw_len;
            rnw_r       <= cmd_rnw;
            req_r       <= swd_request(cmd_apndp, cmd_rnw, cmd_addr);
            wdata_r     <= cmd_wdata;
            ack_r       <= 3'b000;
            bit_cnt_r   <= 6'd0;
            state_r     <= cmd_raw ? ST_RAW : ST_REQ;
            swdio_oe_r  <= 1'b1;
            // First request bit is always the start bit (1).
            swdio_o_r   <= cmd_raw ? cmd_wdata[0] : 1'b1;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_RAW, ST_REQ, ST_TRN1, ST_ACK, ST_RDATA, ST_TRN2, ST_WDATA, ST_TAIL: begin
          if (sample_s && (state_r == ST_ACK)) begin
            ack_r[bit_cnt_r[1:0]] <= swdio_i;
          end else if (sample_s && (state_r == ST_RDATA)) begin
            if (bit_cnt_r == 6'd32) begin
              rx_par_r <= swdio_i;
            end else begin
              rdata_sh_r[bit_cnt_r[4:0]] <= swdio_i;
            end
          end else begin
            rx_par_r <= rx_par_r;
          end
          if (fall_s) begin
            state_r    <= nxt_state_s;
            bit_cnt_r  <= nxt_idx_s;
            swdio_o_r  <= drv_o_s;
            swdio_oe_r <= drv_oe_s;
            if (nxt_state_s == ST_DONE) begin
              rsp_valid_r <= 1'b1;
              rsp_ack     <= raw_r ? 3'b000 : ack_r;
              if (!raw_r && rnw_r && ack_ok_s) begin
                rsp_rdata      <= rdata_sh_r;
                rsp_parity_err <= rx_par_r ^ parity32(rdata_sh_r);
              end else begin
                rsp_parity_err <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
